alu4_req_core: RTL and testbench
================================

Name: alu4_req_core

Overview:
- Registered 4-bit ALU with eight operations selected by a 3-bit opcode: add, subtract, AND, OR, XOR, shift-left, shift-right and magnitude compare.
- Operands and opcode are sampled with a valid strobe; the result and status flags appear one clock later.
- Used as the datapath execution unit behind instruction decode.

Parameters:
- WIDTH, 4, operand and result width in bits; must be at least 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies A, B and sel for this cycle.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- sel  input  3  opcode.
- C  output  WIDTH  registered result.
- carry  output  1  registered carry/borrow/shift-out flag.
- zero  output  1  registered flag, high when C is 0.
- out_valid  output  1  high for one cycle per accepted operation.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: one clock (clk); reset rst_n is asynchronous and active-low.
- While rst_n is low: C = 0, carry = 0, zero = 0, out_valid = 0.
- The first accepted operation is the first rising edge with rst_n high and in_valid high.
- Latency: operation accepted on edge N → C, carry and zero valid and out_valid high after edge N.
- No backpressure; one operation per cycle is accepted, so throughput is 1 per cycle.
- When in_valid is low: out_valid = 0 on the next edge; C, carry and zero hold their last values.
- All arithmetic is unsigned and modulo 2^WIDTH. Opcodes:
  - 000 ADD: C = A+B truncated; carry = bit WIDTH of the sum.
  - 001 SUB: C = A−B truncated (wraps); carry = borrow, i.e. 1 when A<B.
  - 010 AND: C = A&B; carry = 0.
  - 011 OR: C = A|B; carry = 0.
  - 100 XOR: C = A^B; carry = 0.
  - 101 SHL: C = A<<1 with LSB filled 0; carry = old MSB of A; B is ignored.
  - 110 SHR: logical shift, C = A>>1 with MSB filled 0; carry = old LSB of A; B is ignored.
  - 111 CMP: C[1] = (A==B), C[0] = (A>B), upper bits 0; carry = 0.
    - Equal → 0010. Greater → 0001. Less → 0000.
- zero = (next C == 0), evaluated on the same edge as C, for every opcode.
- Reset asserted mid-operation clears all outputs immediately; a pending result is discarded.
- No illegal opcodes exist; all 8 are defined.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100, OP_SHL=3'b101, OP_SHR=3'b110, OP_CMP=3'b111;
  - compare-result bit indices: CMP_GT=0, CMP_EQ=1.
- One combinational sub-module, alu4_req_comb, computes result and carry from A, B and sel.
- The top-level block registers the result, carry, zero and out_valid around alu4_req_comb.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and arbitrary operands → C=0, carry=0, zero=0, out_valid=0. Release reset; next accepted operation produces out_valid=1 one cycle later.
- Arithmetic:
  - A=8, B=6, ADD → C=14, carry=0.
  - A=9, B=3, SUB → C=6, carry=0.
  - A=15, B=1, ADD → C=0, carry=1, zero=1.
  - A=3, B=9, SUB → C=10, carry=1.
- Logic with A=1100, B=1010: AND → 1000; OR → 1110; XOR → 0110; all carry=0.
- Shifts:
  - A=0101, SHL → 1010, carry=0.
  - A=1001, SHR → 0100, carry=1.
  - A=1000, SHL → 0000, carry=1, zero=1.
- Compare:
  - A=5, B=5 → 0010.
  - A=7, B=3 → 0001.
  - A=2, B=9 → 0000 with zero=1.
- Handshake: back-to-back in_valid for 3 cycles → 3 consecutive out_valid pulses with matching results. Drop in_valid → out_valid=0 and C holds its value. Pulse rst_n low mid-stream → outputs clear asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and compare-result bit positions for the 4-bit ALU
package alu_pkg;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;
   localparam int CMP_GT = 0;
   localparam int CMP_EQ = 1;
endpackage

// File: rtl/alu4_req_comb.sv
// alu4_req_comb: combinational result and carry for the eight ALU opcodes
module alu4_req_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_sel,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry
);
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;
   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   // the extra bit of an unsigned subtract is the borrow, set exactly when A < B
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};
   always_comb begin
      o_result = '0;
      o_carry  = 1'b0;
      case (i_sel)
         OP_ADD:  {o_carry, o_result} = w_sum;
         OP_SUB:  {o_carry, o_result} = w_diff;
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_XOR:  o_result = i_a ^ i_b;
         OP_SHL:  {o_carry, o_result} = {i_a, 1'b0};
         OP_SHR:  {o_result, o_carry} = {1'b0, i_a};
         default: begin
            o_result[CMP_EQ] = i_a == i_b;
            o_result[CMP_GT] = i_a > i_b;
         end
      endcase
   end
endmodule

// File: rtl/alu4_req_core.sv
// alu4_req_core: registered ALU, result and flags one clock after a valid request
module alu4_req_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] C,
   output logic             carry,
   output logic             zero,
   output logic             out_valid
);
   logic [WIDTH-1:0] w_result;
   logic             w_carry;
   logic [WIDTH-1:0] r_c;
   logic             r_carry;
   logic             r_zero;
   logic             r_valid;
   alu4_req_comb #(.WIDTH(WIDTH)) u_comb (
      .i_a      (A),
      .i_b      (B),
      .i_sel    (sel),
      .o_result (w_result),
      .o_carry  (w_carry)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c     <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_c     <= w_result;
            r_carry <= w_carry;
            r_zero  <= w_result == '0;
         end
      end
   end
   assign C         = r_c;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign out_valid = r_valid;
endmodule

// File: tb/tb_alu4_req_core.sv
// tb_alu4_req_core: scoreboard bench for alu4_req_core, per-feature tasks with inline checks
module tb_alu4_req_core;
   import alu_pkg::*;
   typedef struct packed {
      logic [3:0] c;
      logic       carry;
      logic       zero;
   } exp_t;
   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] s;
      logic [3:0] c;
      logic       cy;
      logic       z;
   } vec_t;
   localparam vec_t ARITH [4] = '{
      '{4'd8,  4'd6, OP_ADD, 4'd14, 1'b0, 1'b0},
      '{4'd9,  4'd3, OP_SUB, 4'd6,  1'b0, 1'b0},
      '{4'd15, 4'd1, OP_ADD, 4'd0,  1'b1, 1'b1},
      '{4'd3,  4'd9, OP_SUB, 4'd10, 1'b1, 1'b0}};
   localparam vec_t LOGIC [3] = '{
      '{4'b1100, 4'b1010, OP_AND, 4'b1000, 1'b0, 1'b0},
      '{4'b1100, 4'b1010, OP_OR,  4'b1110, 1'b0, 1'b0},
      '{4'b1100, 4'b1010, OP_XOR, 4'b0110, 1'b0, 1'b0}};
   localparam vec_t SHIFT [3] = '{
      '{4'b0101, 4'b1111, OP_SHL, 4'b1010, 1'b0, 1'b0},
      '{4'b1001, 4'b0110, OP_SHR, 4'b0100, 1'b1, 1'b0},
      '{4'b1000, 4'b0011, OP_SHL, 4'b0000, 1'b1, 1'b1}};
   localparam vec_t CMP [3] = '{
      '{4'd5, 4'd5, OP_CMP, 4'b0010, 1'b0, 1'b0},
      '{4'd7, 4'd3, OP_CMP, 4'b0001, 1'b0, 1'b0},
      '{4'd2, 4'd9, OP_CMP, 4'b0000, 1'b0, 1'b1}};
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] A = '0;
   logic [3:0] B = '0;
   logic [2:0] sel = '0;
   logic [3:0] C;
   logic       carry;
   logic       zero;
   logic       out_valid;
   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail = 0;
   alu4_req_core #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .sel       (sel),
      .C         (C),
      .carry     (carry),
      .zero      (zero),
      .out_valid (out_valid)
   );
   always #5 clk = ~clk;
   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
      exp_t       e;
      logic [4:0] t;
      e = '0;
      case (s)
         3'd0: begin t = a + b; e.c = t[3:0]; e.carry = t[4]; end
         3'd1: begin e.c = a - b; e.carry = a < b; end
         3'd2: e.c = a & b;
         3'd3: e.c = a | b;
         3'd4: e.c = a ^ b;
         3'd5: begin e.c = {a[2:0], 1'b0}; e.carry = a[3]; end
         3'd6: begin e.c = {1'b0, a[3:1]}; e.carry = a[0]; end
         default: e.c = {2'b00, a == b, a > b};
      endcase
      e.zero = e.c == 4'd0;
      return e;
   endfunction
   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s, input exp_t e);
      A = a;
      B = b;
      sel = s;
      in_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      exp_t e;
      in_valid = 1'b1;
      A = 4'd15;
      B = 4'd1;
      sel = OP_ADD;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({C, carry, zero, out_valid} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_hold got C=%h carry=%b zero=%b ov=%b exp all 0", C, carry, zero, out_valid);
      end
      rst_n = 1'b1;
      drive(4'd8, 4'd6, OP_ADD, '{4'd14, 1'b0, 1'b0});
      e = sb.pop_front();
      n_tests++;
      if ({C, carry, zero, out_valid} !== {e.c, e.carry, e.zero, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_first_op got C=%h carry=%b zero=%b ov=%b exp C=%h carry=%b zero=%b ov=1",
                  C, carry, zero, out_valid, e.c, e.carry, e.zero);
      end
   endtask
   task automatic test_arith;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive(ARITH[i].a, ARITH[i].b, ARITH[i].s, '{ARITH[i].c, ARITH[i].cy, ARITH[i].z});
         e = sb.pop_front();
         n_tests++;
         if ({C, carry, zero, out_valid} !== {e.c, e.carry, e.zero, 1'b1}) begin
            n_fail++;
            $display("FAIL arith[%0d] got C=%h carry=%b zero=%b ov=%b exp C=%h carry=%b zero=%b ov=1",
                     i, C, carry, zero, out_valid, e.c, e.carry, e.zero);
         end
      end
   endtask
   task automatic test_logic;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive(LOGIC[i].a, LOGIC[i].b, LOGIC[i].s, '{LOGIC[i].c, LOGIC[i].cy, LOGIC[i].z});
         e = sb.pop_front();
         n_tests++;
         if ({C, carry, zero, out_valid} !== {e.c, e.carry, e.zero, 1'b1}) begin
            n_fail++;
            $display("FAIL logic[%0d] got C=%h carry=%b zero=%b ov=%b exp C=%h carry=%b zero=%b ov=1",
                     i, C, carry, zero, out_valid, e.c, e.carry, e.zero);
         end
      end
   endtask
   task automatic test_shift;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive(SHIFT[i].a, SHIFT[i].b, SHIFT[i].s, '{SHIFT[i].c, SHIFT[i].cy, SHIFT[i].z});
         e = sb.pop_front();
         n_tests++;
         if ({C, carry, zero, out_valid} !== {e.c, e.carry, e.zero, 1'b1}) begin
            n_fail++;
            $display("FAIL shift[%0d] got C=%h carry=%b zero=%b ov=%b exp C=%h carry=%b zero=%b ov=1",
                     i, C, carry, zero, out_valid, e.c, e.carry, e.zero);
         end
      end
   endtask
   task automatic test_compare;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive(CMP[i].a, CMP[i].b, CMP[i].s, '{CMP[i].c, CMP[i].cy, CMP[i].z});
         e = sb.pop_front();
         n_tests++;
         if ({C, carry, zero, out_valid} !== {e.c, e.carry, e.zero, 1'b1}) begin
            n_fail++;
            $display("FAIL cmp[%0d] got C=%h carry=%b zero=%b ov=%b exp C=%h carry=%b zero=%b ov=1",
                     i, C, carry, zero, out_valid, e.c, e.carry, e.zero);
         end
      end
   endtask
   task automatic test_random;
      exp_t       e;
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] s;
      for (int i = 0; i < 48; i++) begin
         a = 4'($urandom_range(15));
         b = 4'($urandom_range(15));
         s = 3'(i % 8);
         drive(a, b, s, model(a, b, s));
         e = sb.pop_front();
         n_tests++;
         if ({C, carry, zero, out_valid} !== {e.c, e.carry, e.zero, 1'b1}) begin
            n_fail++;
            $display("FAIL random[%0d] a=%h b=%h sel=%0d got C=%h carry=%b zero=%b ov=%b exp C=%h carry=%b zero=%b",
                     i, a, b, s, C, carry, zero, out_valid, e.c, e.carry, e.zero);
         end
      end
   endtask
   task automatic test_back_to_back;
      exp_t e;
      exp_t last;
      last = '0;
      for (int i = 0; i < 3; i++) begin
         drive(4'(3 + i), 4'(2 * i), OP_ADD, model(4'(3 + i), 4'(2 * i), OP_ADD));
         last = sb.pop_front();
         n_tests++;
         if ({C, carry, zero, out_valid} !== {last.c, last.carry, last.zero, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b[%0d] got C=%h carry=%b zero=%b ov=%b exp C=%h carry=%b zero=%b ov=1",
                     i, C, carry, zero, out_valid, last.c, last.carry, last.zero);
         end
      end
      in_valid = 1'b0;
      A = 4'd15;
      B = 4'd15;
      sel = OP_ADD;
      @(posedge clk);
      #1;
      n_tests++;
      if ({C, carry, zero, out_valid} !== {last.c, last.carry, last.zero, 1'b0}) begin
         n_fail++;
         $display("FAIL idle_hold got C=%h carry=%b zero=%b ov=%b exp C=%h carry=%b zero=%b ov=0",
                  C, carry, zero, out_valid, last.c, last.carry, last.zero);
      end
      drive(4'd8, 4'd6, OP_ADD, '{4'd14, 1'b0, 1'b0});
      e = sb.pop_front();
      n_tests++;
      if ({C, carry, zero, out_valid} !== {e.c, e.carry, e.zero, 1'b1}) begin
         n_fail++;
         $display("FAIL pre_async got C=%h carry=%b zero=%b ov=%b exp C=%h carry=%b zero=%b ov=1",
                  C, carry, zero, out_valid, e.c, e.carry, e.zero);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({C, carry, zero, out_valid} !== 7'd0) begin
         n_fail++;
         $display("FAIL async_reset got C=%h carry=%b zero=%b ov=%b exp all 0", C, carry, zero, out_valid);
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if ({C, out_valid} !== 5'd0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL post_reset got C=%h ov=%b pending=%0d exp C=0 ov=0 pending=0", C, out_valid, sb.size());
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end
   initial begin
      test_reset;
      test_arith;
      test_logic;
      test_shift;
      test_compare;
      test_random;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
